// File: rtl/conversor_bin_bcd_seq.sv
// -----------------------------------------------------------------------------
// conversor_bin_bcd_seq
//
// Sequential binary-to-BCD converter (shift-add-3 / double dabble), one input
// bit per clock. It sits between the adder/subtractor result and the per-digit
// BCD-to-7-segment decoders. With SIGNED=1 the input is two's complement and
// the block outputs magnitude digits plus a sign flag for a minus-sign display.
//
// Parameters
//   WIDTH   binary input width (>= 2)
//   DIGITS  BCD output digits; must hold 2^WIDTH-1 (unsigned) or
//           2^(WIDTH-1) (signed)
//   SIGNED  1 = entrada is two's complement, 0 = unsigned
//
// Ports
//   clk       in   1          rising-edge clock
//   rst_n     in   1          asynchronous active-low reset
//   inicio    in   1          start request, only looked at in IDLE
//   entrada   in   WIDTH      binary value, captured on the accepting edge
//   ocupado   out  1          busy, high in SHIFT and DONE
//   pronto    out  1          one-cycle pulse: new bcd/negativo valid
//   bcd       out  4*DIGITS   result, digit i = bcd[4i+3:4i], digit 0 = units
//   negativo  out  1          sign of the last result (0 when SIGNED=0)
//
// Timing: accept on edge E0, WIDTH shift edges E1..E_WIDTH, pronto high in the
// cycle after E_WIDTH, back to IDLE on the following edge. One conversion
// every WIDTH+2 cycles. All outputs come straight from registers.
// -----------------------------------------------------------------------------
module conversor_bin_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter bit SIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inicio,
    input  logic [WIDTH-1:0]      entrada,
    output logic                  ocupado,
    output logic                  pronto,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negativo
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state,     state_nxt;
    logic [WIDTH-1:0] shreg,    shreg_nxt;
    logic [BW-1:0]   scratch,   scratch_nxt;
    logic [CW-1:0]   counter,   counter_nxt;
    logic            sign_pend, sign_pend_nxt;
    logic [BW-1:0]   bcd_q,     bcd_nxt;
    logic            neg_q,     neg_nxt;

    logic            in_neg;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]   adjusted;
    logic [BW-1:0]   shifted;

    // Add 3 to every digit that is 5 or more, so that the following left
    // shift carries correctly into the next decimal digit. Each digit wraps
    // in 4 bits; a digit >= 5 never exceeds 9 here, so 9+3 = 12 still fits.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] s);
        logic [BW-1:0] r;
        r = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (s[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = s[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Magnitude of the input. Zero has a clear MSB, so it is never negative.
    // The most negative value (e.g. -128 for WIDTH=8) negates to 2^(WIDTH-1),
    // which is still representable as an unsigned WIDTH-bit number, so the
    // shift register only needs WIDTH bits.
    assign in_neg = SIGNED && entrada[WIDTH-1];
    assign mag    = in_neg ? (~entrada + WIDTH'(1)) : entrada;

    // One double-dabble step: adjust digits, then shift {scratch, shreg} left
    // by one, bringing the shift register's MSB into the units digit. The
    // scratch MSB that falls off is always 0 when DIGITS is large enough.
    assign adjusted = add3_digits(scratch);
    assign shifted  = (adjusted << 1) | BW'(shreg[WIDTH-1]);

    // Next-state and datapath logic.
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        scratch_nxt   = scratch;
        counter_nxt   = counter;
        sign_pend_nxt = sign_pend;
        bcd_nxt       = bcd_q;
        neg_nxt       = neg_q;

        case (state)
            IDLE: begin
                if (inicio) begin
                    shreg_nxt     = mag;
                    scratch_nxt   = '0;
                    counter_nxt   = CW'(WIDTH);
                    sign_pend_nxt = in_neg;
                    state_nxt     = SHIFT;
                end
            end

            SHIFT: begin
                scratch_nxt = shifted;
                shreg_nxt   = shreg << 1;
                counter_nxt = counter - CW'(1);
                // This edge performs the last iteration: publish the result
                // now so the outputs never show partial digits.
                if (counter == CW'(1)) begin
                    bcd_nxt   = shifted;
                    neg_nxt   = sign_pend;
                    state_nxt = DONE;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers. A reset in the middle of a conversion
    // discards it along with the previously published result.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            scratch   <= '0;
            counter   <= '0;
            sign_pend <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            scratch   <= scratch_nxt;
            counter   <= counter_nxt;
            sign_pend <= sign_pend_nxt;
            bcd_q     <= bcd_nxt;
            neg_q     <= neg_nxt;
        end
    end

    // Outputs are decoded from registers only; no input reaches them
    // combinationally.
    assign ocupado  = (state != IDLE);
    assign pronto   = (state == DONE);
    assign bcd      = bcd_q;
    assign negativo = neg_q;

endmodule

// File: tb/tb_conversor_bin_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_conversor_bin_bcd_seq
//
// Directed bench for conversor_bin_bcd_seq with WIDTH=8, DIGITS=3. One
// instance is unsigned, the other signed; both share clock and reset.
// Expected digits come from an integer divide/modulo model of the magnitude.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_conversor_bin_bcd_seq;

    localparam int LAT     = 9;   // WIDTH+1
    localparam int PERIOD  = 10;  // WIDTH+2
    localparam int TIMEOUT = 40;

    logic        clk;
    logic        rst_n;

    logic        inicio_u,   inicio_s;
    logic [7:0]  entrada_u,  entrada_s;
    logic        ocupado_u,  ocupado_s;
    logic        pronto_u,   pronto_s;
    logic [11:0] bcd_u,      bcd_s;
    logic        negativo_u, negativo_s;

    int checks;
    int failures;

    conversor_bin_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0)) dut_u (
        .clk      (clk),
        .rst_n    (rst_n),
        .inicio   (inicio_u),
        .entrada  (entrada_u),
        .ocupado  (ocupado_u),
        .pronto   (pronto_u),
        .bcd      (bcd_u),
        .negativo (negativo_u)
    );

    conversor_bin_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .inicio   (inicio_s),
        .entrada  (entrada_s),
        .ocupado  (ocupado_s),
        .pronto   (pronto_s),
        .bcd      (bcd_s),
        .negativo (negativo_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    function automatic int ref_mag(input bit sgn, input logic [7:0] v);
        if (sgn && v[7]) return 256 - int'(v);
        return int'(v);
    endfunction

    function automatic logic [11:0] ref_bcd(input bit sgn, input logic [7:0] v);
        int m;
        m = ref_mag(sgn, v);
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic ref_neg(input bit sgn, input logic [7:0] v);
        return sgn && v[7];
    endfunction

    // ------------------------------------------------------------ accessors
    function automatic logic get_pronto(input bit sel);
        return sel ? pronto_s : pronto_u;
    endfunction

    function automatic logic get_ocupado(input bit sel);
        return sel ? ocupado_s : ocupado_u;
    endfunction

    function automatic logic [11:0] get_bcd(input bit sel);
        return sel ? bcd_s : bcd_u;
    endfunction

    function automatic logic get_neg(input bit sel);
        return sel ? negativo_s : negativo_u;
    endfunction

    task automatic drive(input bit sel, input logic ini, input logic [7:0] v);
        if (sel) begin
            inicio_s  = ini;
            entrada_s = v;
        end else begin
            inicio_u  = ini;
            entrada_u = v;
        end
    endtask

    // One complete conversion with a single-cycle inicio pulse. lat is the
    // cycle (counted from the accepting edge) in which pronto was seen, -1 on
    // timeout. held_ok is cleared if bcd moved before pronto.
    task automatic convert(input bit sel, input logic [7:0] v,
                           output logic [11:0] got_bcd, output logic got_neg,
                           output int lat, output bit held_ok);
        logic [11:0] prev;
        @(negedge clk);
        prev    = get_bcd(sel);
        held_ok = 1'b1;
        lat     = -1;
        got_bcd = 'x;
        got_neg = 1'bx;
        drive(sel, 1'b1, v);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            drive(sel, 1'b0, 8'h00);
            if (get_pronto(sel)) begin
                lat     = k;
                got_bcd = get_bcd(sel);
                got_neg = get_neg(sel);
                break;
            end
            if (get_bcd(sel) !== prev) held_ok = 1'b0;
        end
    endtask

    task automatic check_conv(input string name, input bit sel, input logic [7:0] v);
        logic [11:0] b;
        logic        n;
        int          lat;
        bit          held;
        convert(sel, v, b, n, lat, held);
        checks += 4;
        if (b !== ref_bcd(sel, v)) begin
            failures++;
            $display("FAIL %s bcd in=%02h signed=%0d got=%03h exp=%03h", name, v, sel, b, ref_bcd(sel, v));
        end
        if (n !== ref_neg(sel, v)) begin
            failures++;
            $display("FAIL %s negativo in=%02h signed=%0d got=%b exp=%b", name, v, sel, n, ref_neg(sel, v));
        end
        if (lat != LAT) begin
            failures++;
            $display("FAIL %s latency in=%02h signed=%0d got=%0d exp=%0d", name, v, sel, lat, LAT);
        end
        if (held !== 1'b1) begin
            failures++;
            $display("FAIL %s bcd_changed_before_pronto in=%02h signed=%0d", name, v, sel);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({get_ocupado(s[0]), get_pronto(s[0]), get_neg(s[0]), get_bcd(s[0])} !== 15'd0) begin
                failures++;
                $display("FAIL reset_state signed=%0d got ocupado=%b pronto=%b neg=%b bcd=%03h exp all 0",
                         s, get_ocupado(s[0]), get_pronto(s[0]), get_neg(s[0]), get_bcd(s[0]));
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ocupado_u !== 1'b0 || ocupado_s !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got ocupado_u=%b ocupado_s=%b exp 0", ocupado_u, ocupado_s);
        end
    endtask

    task automatic test_unsigned_max();
        check_conv("unsigned_255", 1'b0, 8'd255);
    endtask

    task automatic test_signed_cases();
        logic [7:0] vec [3] = '{8'h80, 8'hF9, 8'h00};
        foreach (vec[i]) check_conv("signed_directed", 1'b1, vec[i]);
    endtask

    // inicio is raised in cycle 3 (SHIFT) and in cycle 9 (DONE); neither may
    // start a second conversion.
    task automatic test_start_while_busy();
        int          n_pronto;
        int          first_cycle;
        logic [11:0] first_bcd;
        logic        busy_in_done;
        n_pronto     = 0;
        first_cycle  = -1;
        first_bcd    = 'x;
        busy_in_done = 1'bx;
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd42);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (pronto_u) begin
                n_pronto++;
                if (first_cycle < 0) begin
                    first_cycle  = k;
                    first_bcd    = bcd_u;
                    busy_in_done = ocupado_u;
                end
            end
            if (k == 3 || k == 9) drive(1'b0, 1'b1, 8'd200);
            else                  drive(1'b0, 1'b0, 8'd0);
        end
        checks += 4;
        if (n_pronto != 1) begin
            failures++;
            $display("FAIL busy_start pronto_count got=%0d exp=1", n_pronto);
        end
        if (first_cycle != LAT) begin
            failures++;
            $display("FAIL busy_start latency got=%0d exp=%0d", first_cycle, LAT);
        end
        if (first_bcd !== 12'h042) begin
            failures++;
            $display("FAIL busy_start bcd got=%03h exp=042", first_bcd);
        end
        if (busy_in_done !== 1'b1) begin
            failures++;
            $display("FAIL busy_start ocupado_in_done got=%b exp=1", busy_in_done);
        end
    endtask

    // inicio stays high: 99 is accepted at E0, 7 at E10 (first IDLE edge).
    task automatic test_back_to_back();
        int          n;
        int          cyc [2];
        logic [11:0] val [2];
        n = 0;
        cyc = '{-1, -1};
        val = '{12'hxxx, 12'hxxx};
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd99);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == 1) entrada_u = 8'd7;
            if (pronto_u) begin
                if (n < 2) begin
                    cyc[n] = k;
                    val[n] = bcd_u;
                end
                n++;
                if (n == 2) drive(1'b0, 1'b0, 8'd0);
            end
        end
        drive(1'b0, 1'b0, 8'd0);
        checks += 5;
        if (n != 2) begin
            failures++;
            $display("FAIL back_to_back pronto_count got=%0d exp=2", n);
        end
        if (cyc[0] != LAT) begin
            failures++;
            $display("FAIL back_to_back first_latency got=%0d exp=%0d", cyc[0], LAT);
        end
        if (cyc[1] - cyc[0] != PERIOD) begin
            failures++;
            $display("FAIL back_to_back spacing got=%0d exp=%0d", cyc[1] - cyc[0], PERIOD);
        end
        if (val[0] !== 12'h099) begin
            failures++;
            $display("FAIL back_to_back bcd0 got=%03h exp=099", val[0]);
        end
        if (val[1] !== 12'h007) begin
            failures++;
            $display("FAIL back_to_back bcd1 got=%03h exp=007", val[1]);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit quiet;
        // Leave a negative, non-zero result on the outputs first.
        check_conv("pre_reset", 1'b1, 8'hF9);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h85);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (ocupado_s !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset busy_before got=%b exp=1", ocupado_s);
        end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (ocupado_s !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset ocupado got=%b exp=0", ocupado_s);
        end
        if (pronto_s !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset pronto got=%b exp=0", pronto_s);
        end
        if (bcd_s !== 12'h000) begin
            failures++;
            $display("FAIL mid_reset bcd got=%03h exp=000", bcd_s);
        end
        if (negativo_s !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset negativo got=%b exp=0", negativo_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (ocupado_s !== 1'b0 || pronto_s !== 1'b0 || bcd_s !== 12'h000 || negativo_s !== 1'b0)
                quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset stays_idle_after_release got activity exp none");
        end
        check_conv("post_reset", 1'b1, 8'hF6);
    endtask

    task automatic test_exhaustive();
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 256; v++) begin
                check_conv("exhaustive", s[0], 8'(v));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);

        test_reset();
        test_unsigned_max();
        test_signed_cases();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_shift();
        test_exhaustive();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
